// File: rtl/fft_stream_pkg.sv
// Shared types and elaboration-time helpers for the streaming FFT engine.
package fft_stream_pkg;

  localparam int unsigned D_WIDTH = 16;
  localparam real         PI      = 3.14159265358979323846;

  typedef struct packed {
    logic signed [D_WIDTH-1:0] re;
    logic signed [D_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  // Reverses the low log2n bits of idx (log2n <= 10).
  function automatic logic [9:0] bitrev(input logic [9:0] idx, input int unsigned log2n);
    logic [9:0] r;
    r = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (i < log2n) r[4'(i)] = idx[4'(log2n - 1 - i)];
    end
    return r;
  endfunction

  // Entry k of the rounded cos (want_sin=0) or sin (want_sin=1) table for an n-point transform.
  function automatic int tw_val(input int unsigned k, input int unsigned n,
                                input int unsigned frac, input logic want_sin);
    real ang;
    real v;
    ang = 2.0 * PI * $itor(k) / $itor(n);
    v   = (want_sin ? $sin(ang) : $cos(ang)) * $itor(32'd1 << frac);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/fft_stream_engine_if.sv
// Sample-in / bin-out stream bundle of the FFT engine.
interface fft_stream_engine_if;
  import fft_stream_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic signed [D_WIDTH-1:0] in_re;
  logic signed [D_WIDTH-1:0] in_im;
  logic                      ifft;
  logic                      scale_en;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [D_WIDTH-1:0] out_re;
  logic signed [D_WIDTH-1:0] out_im;
  logic                      out_last;

  modport master (
    output in_valid, in_re, in_im, ifft, scale_en, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, ifft, scale_en, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/fft_bfly_unit.sv
// Combinational radix-2 butterfly: a = top + bot*W, b = top - bot*W with rounding,
// optional halving and saturation; clip_o flags any saturated component.
module fft_bfly_unit
  import fft_stream_pkg::*;
#(
  parameter int unsigned TW_WIDTH = 10,
  parameter int unsigned TW_FRAC  = 8
) (
  input  cplx_t                      top_i,
  input  cplx_t                      bot_i,
  input  logic signed [TW_WIDTH-1:0] w_re_i,
  input  logic signed [TW_WIDTH-1:0] w_im_i,
  input  logic                       scale_en_i,
  output cplx_t                      a_o,
  output cplx_t                      b_o,
  output logic                       clip_o
);
  localparam int unsigned PW = D_WIDTH + TW_WIDTH + 1;
  localparam int unsigned SW = D_WIDTH + 2;
  localparam logic signed [PW-1:0] RND  = PW'(2 ** (TW_FRAC - 1));
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** (D_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

  logic signed [PW-1:0] p_re, p_im;
  logic signed [SW-1:0] t_re, t_im, a_re, a_im, b_re, b_im;
  logic [3:0]           clips;

  function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] x, input logic en);
    return en ? ((x + SW'(1)) >>> 1) : x;
  endfunction

  // Returns {clip, saturated value}.
  function automatic logic [D_WIDTH:0] sat(input logic signed [SW-1:0] x);
    if (x > MAXV) return {1'b1, D_WIDTH'(MAXV)};
    if (x < MINV) return {1'b1, D_WIDTH'(MINV)};
    return {1'b0, D_WIDTH'(x)};
  endfunction

  always_comb begin
    p_re = PW'(bot_i.re) * PW'(w_re_i) - PW'(bot_i.im) * PW'(w_im_i);
    p_im = PW'(bot_i.re) * PW'(w_im_i) + PW'(bot_i.im) * PW'(w_re_i);
    t_re = SW'((p_re + RND) >>> TW_FRAC);
    t_im = SW'((p_im + RND) >>> TW_FRAC);
    a_re = halve(SW'(top_i.re) + t_re, scale_en_i);
    a_im = halve(SW'(top_i.im) + t_im, scale_en_i);
    b_re = halve(SW'(top_i.re) - t_re, scale_en_i);
    b_im = halve(SW'(top_i.im) - t_im, scale_en_i);
    {clips[0], a_o.re} = sat(a_re);
    {clips[1], a_o.im} = sat(a_im);
    {clips[2], b_o.re} = sat(b_re);
    {clips[3], b_o.im} = sat(b_im);
    clip_o = |clips;
  end

endmodule

// File: rtl/fft_stream_engine.sv
// Iterative radix-2 DIT FFT/IFFT: loads a frame in bit-reversed order, runs one in-place
// butterfly per clock over log2(N) stages, then streams the bins out in natural order.
module fft_stream_engine
  import fft_stream_pkg::*;
#(
  parameter int unsigned N_POINTS = 64,
  parameter int unsigned LOG2_N   = 6,
  parameter int unsigned TW_WIDTH = 10,
  parameter int unsigned TW_FRAC  = 8
) (
  input  logic               clk,
  input  logic               rst,
  fft_stream_engine_if.slave s,
  output logic               busy,
  output logic               overflow
);
  localparam int unsigned HALF_N = N_POINTS / 2;
  localparam int unsigned IW     = LOG2_N;
  localparam int unsigned JW     = LOG2_N - 1;
  localparam int unsigned SGW    = $clog2(LOG2_N);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, oidx_q, oidx_d;
  logic [SGW-1:0]  stage_q, stage_d;
  logic [JW-1:0]   bfly_q, bfly_d;
  logic            ifft_q, ifft_d, scale_q, scale_d, ovf_q, ovf_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d, busy_q, busy_d;
  cplx_t           out_q, out_d;
  cplx_t           mem_q [N_POINTS];
  cplx_t           mem_d [N_POINTS];

  logic signed [TW_WIDTH-1:0] cos_rom [HALF_N];
  logic signed [TW_WIDTH-1:0] sin_rom [HALF_N];
  logic signed [TW_WIDTH-1:0] w_re, w_im;
  logic [IW-1:0]   j_ext, half_v, lo_mask, top_a, bot_a;
  logic [JW-1:0]   tw_k;
  cplx_t           bf_a, bf_b;
  logic            bf_clip;

  // Twiddle tables are constant per elaboration.
  for (genvar g = 0; g < HALF_N; g++) begin : g_tw
    assign cos_rom[g] = TW_WIDTH'(tw_val(g, N_POINTS, TW_FRAC, 1'b0));
    assign sin_rom[g] = TW_WIDTH'(tw_val(g, N_POINTS, TW_FRAC, 1'b1));
  end

  // Butterfly addresses and twiddle index for (stage_q, bfly_q).
  always_comb begin
    j_ext   = IW'(bfly_q);
    half_v  = IW'(1) << stage_q;
    lo_mask = half_v - IW'(1);
    top_a   = (((j_ext >> stage_q) << stage_q) << 1) | (j_ext & lo_mask);
    bot_a   = top_a + half_v;
    tw_k    = JW'((j_ext & lo_mask) << (SGW'(LOG2_N - 1) - stage_q));
  end

  assign w_re = cos_rom[tw_k];
  assign w_im = ifft_q ? sin_rom[tw_k] : -sin_rom[tw_k];

  fft_bfly_unit #(.TW_WIDTH(TW_WIDTH), .TW_FRAC(TW_FRAC)) u_bfly (
    .top_i      (mem_q[top_a]),
    .bot_i      (mem_q[bot_a]),
    .w_re_i     (w_re),
    .w_im_i     (w_im),
    .scale_en_i (scale_q),
    .a_o        (bf_a),
    .b_o        (bf_b),
    .clip_o     (bf_clip)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    oidx_d     = oidx_q;
    stage_d    = stage_q;
    bfly_d     = bfly_q;
    ifft_d     = ifft_q;
    scale_d    = scale_q;
    ovf_d      = ovf_q;
    out_d      = out_q;
    out_last_d = out_last_q;
    mem_d      = mem_q;
    unique case (state_q)
      LOAD: begin
        if (s.in_valid && in_ready_q) begin
          mem_d[IW'(bitrev(10'(idx_q), LOG2_N))] = cplx_t'{re: s.in_re, im: s.in_im};
          idx_d = idx_q + IW'(1);
          if (idx_q == '0) begin
            ifft_d  = s.ifft;
            scale_d = s.scale_en;
            ovf_d   = 1'b0;
          end
          if (idx_q == IW'(N_POINTS - 1)) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        mem_d[top_a] = bf_a;
        mem_d[bot_a] = bf_b;
        if (bf_clip) ovf_d = 1'b1;
        if (bfly_q == JW'(HALF_N - 1)) begin
          bfly_d = '0;
          if (stage_q == SGW'(LOG2_N - 1)) begin
            stage_d    = '0;
            oidx_d     = '0;
            state_d    = UNLOAD;
            out_d      = mem_d[IW'(0)];
            out_last_d = 1'b0;
          end else begin
            stage_d = stage_q + SGW'(1);
          end
        end else begin
          bfly_d = bfly_q + JW'(1);
        end
      end
      UNLOAD: begin
        if (s.out_ready && out_valid_q) begin
          if (out_last_q) begin
            state_d    = LOAD;
            oidx_d     = '0;
            out_last_d = 1'b0;
          end else begin
            oidx_d     = oidx_q + IW'(1);
            out_d      = mem_q[oidx_d];
            out_last_d = (oidx_d == IW'(N_POINTS - 1));
          end
        end
      end
      default: state_d = LOAD;
    endcase
    in_ready_d  = (state_d == LOAD);
    busy_d      = (state_d == COMPUTE);
    out_valid_d = (state_d == UNLOAD);
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      oidx_q      <= '0;
      stage_q     <= '0;
      bfly_q      <= '0;
      ifft_q      <= 1'b0;
      scale_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_q       <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      oidx_q      <= oidx_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      ifft_q      <= ifft_d;
      scale_q     <= scale_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
      mem_q       <= mem_d;
    end
  end

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = out_valid_q;
  assign s.out_re    = out_q.re;
  assign s.out_im    = out_q.im;
  assign s.out_last  = out_last_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fft_stream_engine.sv
// Directed bench for fft_stream_engine: impulse, DC, shifted impulse, saturation,
// back-pressure and mid-compute reset with hand-computed expected bins.
module tb_fft_stream_engine;

  localparam int N = 64;

  logic clk = 1'b0;
  logic rst;
  logic busy, overflow;

  fft_stream_engine_if sif();

  fft_stream_engine #(
    .N_POINTS (64),
    .LOG2_N   (6),
    .TW_WIDTH (10),
    .TW_FRAC  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (sif),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic signed [15:0] xr [N];
  logic signed [15:0] res_re [N];
  logic signed [15:0] res_im [N];
  logic signed [15:0] hr, hi;
  int   lat, last_bad, valid_bad, bp_bad, bad;
  logic ovf_first;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic fill(input logic signed [15:0] v0, input logic signed [15:0] rest, input int pos);
    for (int i = 0; i < N; i++) xr[i] = rest;
    xr[pos] = v0;
  endtask

  // Drives one frame; each posedge-to-posedge window contains one accepting negedge.
  task automatic send_frame(input logic inv, input logic scl);
    sif.ifft     = inv;
    sif.scale_en = scl;
    for (int i = 0; i < N; i++) begin
      sif.in_valid = 1'b1;
      sif.in_re    = xr[i];
      sif.in_im    = '0;
      @(posedge clk);
      if (i == 0) ovf_first = overflow;
    end
    sif.in_valid = 1'b0;
    sif.in_re    = '0;
  endtask

  // Collects all bins; optionally stalls 5 cycles while bin bp_at is presented.
  task automatic recv_frame(input int bp_at);
    lat = 0;
    while (!sif.out_valid && lat < 400) begin
      @(posedge clk);
      lat++;
    end
    sif.out_ready = 1'b1;
    last_bad  = 0;
    valid_bad = 0;
    bp_bad    = 0;
    for (int b = 0; b < N; b++) begin
      if (b == bp_at) begin
        sif.out_ready = 1'b0;
        hr = sif.out_re;
        hi = sif.out_im;
        repeat (5) begin
          @(posedge clk);
          if (sif.out_re !== hr || sif.out_im !== hi || sif.out_valid !== 1'b1 || sif.out_last !== 1'b0)
            bp_bad++;
        end
        sif.out_ready = 1'b1;
      end
      if (sif.out_valid !== 1'b1) valid_bad++;
      if (sif.out_last !== (b == N - 1)) last_bad++;
      res_re[b] = sif.out_re;
      res_im[b] = sif.out_im;
      @(posedge clk);
    end
  endtask

  initial begin
    rst           = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_re     = '0;
    sif.in_im     = '0;
    sif.ifft      = 1'b0;
    sif.scale_en  = 1'b0;
    sif.out_ready = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    check("rst_in_ready",  32'(sif.in_ready), 1);
    check("rst_out_valid", 32'(sif.out_valid), 0);
    check("rst_out_re",    32'(sif.out_re), 0);
    check("rst_out_last",  32'(sif.out_last), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_overflow",  32'(overflow), 0);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);

    // Impulse 1000 at x[0]
    fill(16'sd1000, 16'sd0, 0);
    send_frame(1'b0, 1'b0);
    check("imp_in_ready_compute", 32'(sif.in_ready), 0);
    @(posedge clk);
    check("imp_busy", 32'(busy), 1);
    recv_frame(-1);
    check("imp_latency_window", 32'((lat >= 190) && (lat <= 192)), 1);
    bad = 0;
    for (int b = 0; b < N; b++) if (res_re[b] !== 16'sd1000 || res_im[b] !== 16'sd0) bad++;
    check("imp_bins_bad", bad, 0);
    check("imp_bin63_re", 32'(res_re[63]), 1000);
    check("imp_valid_bad", valid_bad, 0);
    check("imp_last_bad", last_bad, 0);
    check("imp_overflow", 32'(overflow), 0);

    // DC 100, unscaled
    fill(16'sd100, 16'sd100, 0);
    send_frame(1'b0, 1'b0);
    recv_frame(-1);
    check("dc_bin0_re", 32'(res_re[0]), 6400);
    check("dc_bin0_im", 32'(res_im[0]), 0);
    bad = 0;
    for (int b = 1; b < N; b++) if (res_re[b] !== 16'sd0 || res_im[b] !== 16'sd0) bad++;
    check("dc_other_bad", bad, 0);

    // DC 100, scaled per stage
    send_frame(1'b0, 1'b1);
    recv_frame(-1);
    check("dcs_bin0_re", 32'(res_re[0]), 100);
    bad = 0;
    for (int b = 1; b < N; b++) if (res_re[b] !== 16'sd0 || res_im[b] !== 16'sd0) bad++;
    check("dcs_other_bad", bad, 0);

    // Shifted impulse 256 at x[1], forward then inverse
    fill(16'sd256, 16'sd0, 1);
    send_frame(1'b0, 1'b0);
    recv_frame(-1);
    check("shf_bin0_re",  32'(res_re[0]), 256);
    check("shf_bin16_re", 32'(res_re[16]), 0);
    check("shf_bin16_im", 32'(res_im[16]), -256);
    check("shf_bin32_re", 32'(res_re[32]), -256);
    check("shf_bin32_im", 32'(res_im[32]), 0);
    send_frame(1'b1, 1'b0);
    recv_frame(-1);
    check("ishf_bin16_re", 32'(res_re[16]), 0);
    check("ishf_bin16_im", 32'(res_im[16]), 256);
    check("ishf_bin32_re", 32'(res_re[32]), -256);

    // Saturation
    fill(16'sd32767, 16'sd32767, 0);
    send_frame(1'b0, 1'b0);
    recv_frame(-1);
    check("sat_bin0_re", 32'(res_re[0]), 32767);
    check("sat_bin0_im", 32'(res_im[0]), 0);
    check("sat_overflow_sticky", 32'(overflow), 1);

    // Next frame clears overflow; back-pressure at bin 10
    fill(16'sd1000, 16'sd0, 0);
    send_frame(1'b0, 1'b0);
    check("bp_ovf_cleared_first", 32'(ovf_first), 0);
    recv_frame(10);
    check("bp_stable_bad", bp_bad, 0);
    check("bp_bin10_re", 32'(res_re[10]), 1000);
    check("bp_last_bad", last_bad, 0);
    check("bp_valid_bad", valid_bad, 0);
    check("bp_in_ready_after", 32'(sif.in_ready), 1);
    check("bp_out_valid_after", 32'(sif.out_valid), 0);
    check("bp_overflow", 32'(overflow), 0);

    // Reset at butterfly 50 of a compute pass, then a fresh frame
    fill(16'sd1000, 16'sd0, 0);
    send_frame(1'b0, 1'b0);
    repeat (50) @(posedge clk);
    check("mid_busy_before", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy",      32'(busy), 0);
    check("mid_rst_in_ready",  32'(sif.in_ready), 1);
    check("mid_rst_out_valid", 32'(sif.out_valid), 0);
    check("mid_rst_out_im",    32'(sif.out_im), 0);
    check("mid_rst_overflow",  32'(overflow), 0);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    fill(16'sd500, 16'sd0, 0);
    send_frame(1'b0, 1'b0);
    recv_frame(-1);
    bad = 0;
    for (int b = 0; b < N; b++) if (res_re[b] !== 16'sd500 || res_im[b] !== 16'sd0) bad++;
    check("post_rst_bins_bad", bad, 0);
    check("post_rst_valid_bad", valid_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stream_engine.md
Name: fft_stream_engine

Overview:
- Parametrised, iterative radix-2 DIT FFT/IFFT engine that replaces the fixed 64-point parallel-array FFT.
- Samples arrive over a valid/ready stream in natural order and are stored internally in bit-reversed order.
- Computes one butterfly per clock over log2(N) stages, then streams results out in natural order with back-pressure.
- Adds runtime FFT/IFFT selection, optional per-stage 1/2 scaling, rounding, saturation and a sticky overflow flag.

Parameters:
- N_POINTS, 64, transform length (power of 2, 4..1024).
- LOG2_N, 6, log2(N_POINTS).
- D_WIDTH, 16, signed sample width (real and imaginary each).
- TW_WIDTH, 10, signed twiddle width.
- TW_FRAC, 8, twiddle fraction bits (+1.0 = 256).

Ports:
- clk  in  1  clock; all state updates on negedge clk.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine accepts a sample.
- in_re  in  D_WIDTH  signed real part.
- in_im  in  D_WIDTH  signed imaginary part.
- ifft  in  1  1 = inverse transform; sampled with the first accepted sample of a frame.
- scale_en  in  1  1 = divide by 2 at every stage; sampled like ifft.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_re  out  D_WIDTH  signed result, real part.
- out_im  out  D_WIDTH  signed result, imaginary part.
- out_last  out  1  marks bin N_POINTS-1.
- busy  out  1  high in COMPUTE.
- overflow  out  1  sticky saturation flag for the current frame.

Behaviour:
- Reset: state LOAD, all counters 0, sample memory 0, in_ready=1, out_valid=0, out_re/out_im=0, out_last=0, busy=0, overflow=0. Reset asserted mid-frame aborts the frame and discards all data.
- LOAD state:
  - in_ready=1.
  - Each in_valid&in_ready handshake writes the sample to mem[bitrev(idx)] and increments idx.
  - The first handshake of a frame latches ifft/scale_en and clears overflow.
  - The handshake at idx=N_POINTS-1 moves the state to COMPUTE on the next edge.
- COMPUTE state:
  - in_ready=0, busy=1.
  - Stage s runs 0..LOG2_N-1 and butterfly j runs 0..N/2-1, one per cycle, for LOG2_N*N/2 cycles total (192 at defaults).
  - half = 2^s; top = ((j>>s)<<(s+1)) | (j&(half-1)); bot = top+half; k = (j&(half-1))<<(LOG2_N-1-s).
  - Twiddle W = cos(2πk/N) - j·sin(2πk/N); the sine term is negated when ifft is latched.
  - Butterfly arithmetic:
    - t = mem[bot]·W, computed at full width.
    - Round t by adding 2^(TW_FRAC-1), then arithmetic shift right by TW_FRAC.
    - Form a = mem[top]+t and b = mem[top]-t at D_WIDTH+2 bits.
    - If scale_en, apply round-half-up then shift right by 1.
    - Saturate to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1]; any clip sets overflow.
  - Both results are written in the same cycle.
  - After the last butterfly of the last stage, move to UNLOAD.
- UNLOAD state:
  - out_valid=1; out_re/out_im = mem[oidx]; out_last = (oidx==N_POINTS-1).
  - Data must hold stable while out_ready=0.
  - A handshake increments oidx. The handshake on out_last returns to LOAD with in_ready=1 on the next cycle.
  - No input is accepted during COMPUTE or UNLOAD.
- Output values are not normalised by 1/N except through scale_en; IFFT with scale_en yields x·(1/N).
- overflow holds until the first handshake of the next frame or reset.

Decomposition:
- Package fft_stream_pkg holds:
  - cplx_t struct (re, im, each D_WIDTH signed);
  - state enum {LOAD, COMPUTE, UNLOAD};
  - bitrev function parameterised by LOG2_N;
  - twiddle constant function giving the rounded cos/sin table of N/2 entries, TW_WIDTH wide.
- One sub-module, fft_bfly_unit: purely combinational multiply/round/add/subtract/scale/saturate, with a clip output.
- The FSM, address generation and memory stay in fft_stream_engine.

Test Plan:
- Impulse: x[0]=1000+0j, rest 0, scale_en=0 → all 64 bins 1000+0j, overflow=0; first out_valid 192 cycles after the last input handshake (±1 for the state transition).
- DC: all x=100+0j, scale_en=0 → bin0=6400+0j, bins 1..63 = 0; with scale_en=1 → bin0=100, others 0.
- Shifted impulse: x[1]=256+0j, FFT → bin16=0-256j, bin32=-256+0j; repeat with ifft=1 → bin16=0+256j.
- Saturation: all x=32767+0j, scale_en=0 → bin0=32767, overflow=1. The next frame's first handshake clears overflow to 0.
- Back-pressure: hold out_ready=0 for 5 cycles at oidx=10 → out_re/out_im/out_valid stable; out_last only on bin 63; in_ready=1 the cycle after the final handshake.
- Reset mid-COMPUTE: assert rst at butterfly 50 → all outputs at reset values. After release, a fresh impulse frame produces the correct result.
